// File: rtl/axi_sp_ram_ctrl.sv
// rtl/axi_sp_ram_ctrl.sv - AXI4 slave bridging read/write bursts onto one single-port SRAM
module axi_sp_ram_ctrl #(
  parameter int          ID_WIDTH = 4,
  parameter logic [31:0] MEM_SIZE = 32'h10000
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [ID_WIDTH-1:0]                i_awid,
  input  logic [31:0]                        i_awaddr,
  input  logic [7:0]                         i_awlen,
  input  logic [1:0]                         i_awburst,
  input  logic                               i_awvalid,
  output logic                               o_awready,
  input  logic [63:0]                        i_wdata,
  input  logic [7:0]                         i_wstrb,
  input  logic                               i_wlast,
  input  logic                               i_wvalid,
  output logic                               o_wready,
  output logic [ID_WIDTH-1:0]                o_bid,
  output logic [1:0]                         o_bresp,
  output logic                               o_bvalid,
  input  logic                               i_bready,
  input  logic [ID_WIDTH-1:0]                i_arid,
  input  logic [31:0]                        i_araddr,
  input  logic [7:0]                         i_arlen,
  input  logic [1:0]                         i_arburst,
  input  logic                               i_arvalid,
  output logic                               o_arready,
  output logic [ID_WIDTH-1:0]                o_rid,
  output logic [63:0]                        o_rdata,
  output logic [1:0]                         o_rresp,
  output logic                               o_rlast,
  output logic                               o_rvalid,
  input  logic                               i_rready,
  output logic [$clog2(MEM_SIZE)-4:0]        o_mem_addr,
  output logic [7:0]                         o_mem_we,
  output logic [63:0]                        o_mem_wdata,
  output logic                               o_mem_en,
  input  logic [63:0]                        i_mem_rdata
);
  localparam int AW = $clog2(MEM_SIZE) - 3;

  typedef enum logic [2:0] {IDLE, WR, WRESP, RD_ADDR, RD_DATA} state_t;

  state_t                state_q, state_d;
  logic                  prio_q, prio_d;      // 0: write wins a tie, 1: read wins
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [1:0]            burst_q, burst_d;
  logic [7:0]            beat_q, beat_d;
  logic [63:0]           rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic [AW-1:0]         next_addr;
  logic                  idle, aw_ok, ar_ok;
  logic                  unused_bits;

  assign unused_bits = ^{i_awaddr[31:AW+3], i_awaddr[2:0], i_araddr[31:AW+3], i_araddr[2:0], i_wlast};

  assign next_addr = (burst_q == 2'b00) ? addr_q : addr_q + 1'b1;
  assign o_bid     = id_q;
  assign o_rid     = id_q;
  assign o_bresp   = 2'b00;
  assign o_rresp   = 2'b00;
  assign o_rdata   = rdata_q;
  assign o_rvalid  = rvalid_q;
  assign o_rlast   = rvalid_q && (beat_q == len_q);

  // Ready is withheld from the losing side of a tie so only one handshake completes.
  assign idle      = (state_q == IDLE) && rst_n;
  assign aw_ok     = idle && !(i_arvalid && prio_q);
  assign ar_ok     = idle && !(i_awvalid && !prio_q);
  assign o_awready = aw_ok;
  assign o_arready = ar_ok;

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    id_d        = id_q;
    addr_d      = addr_q;
    len_d       = len_q;
    burst_d     = burst_q;
    beat_d      = beat_q;
    rdata_d     = rdata_q;
    rvalid_d    = rvalid_q;
    o_wready    = 1'b0;
    o_bvalid    = 1'b0;
    o_mem_en    = 1'b0;
    o_mem_we    = 8'h00;
    o_mem_wdata = 64'h0;
    o_mem_addr  = '0;
    case (state_q)
      IDLE: begin
        if (i_awvalid && aw_ok) begin
          id_d    = i_awid;
          addr_d  = i_awaddr[AW+2:3];
          len_d   = i_awlen;
          burst_d = i_awburst;
          beat_d  = 8'd0;
          state_d = WR;
          if (i_arvalid) prio_d = 1'b1;
        end else if (i_arvalid && ar_ok) begin
          id_d     = i_arid;
          addr_d   = i_araddr[AW+2:3];
          len_d    = i_arlen;
          burst_d  = i_arburst;
          beat_d   = 8'd0;
          rvalid_d = 1'b0;
          state_d  = RD_ADDR;
          if (i_awvalid) prio_d = 1'b0;
        end
      end
      WR: begin
        o_wready = 1'b1;
        if (i_wvalid) begin
          o_mem_en    = 1'b1;
          o_mem_we    = i_wstrb;
          o_mem_wdata = i_wdata;
          o_mem_addr  = addr_q;
          addr_d      = next_addr;
          beat_d      = beat_q + 8'd1;
          if (beat_q == len_q) state_d = WRESP;
        end
      end
      WRESP: begin
        o_bvalid = 1'b1;
        if (i_bready) state_d = IDLE;
      end
      RD_ADDR: begin
        o_mem_en   = 1'b1;
        o_mem_addr = addr_q;
        state_d    = RD_DATA;
      end
      RD_DATA: begin
        // First cycle captures the SRAM word; rvalid follows on the next cycle.
        if (!rvalid_q) begin
          rdata_d  = i_mem_rdata;
          rvalid_d = 1'b1;
        end else if (i_rready) begin
          rvalid_d = 1'b0;
          if (beat_q == len_q) begin
            state_d = IDLE;
          end else begin
            beat_d  = beat_q + 8'd1;
            addr_d  = next_addr;
            state_d = RD_ADDR;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      prio_q   <= 1'b0;
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= 8'd0;
      burst_q  <= 2'b00;
      beat_q   <= 8'd0;
      rdata_q  <= 64'h0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      id_q     <= id_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      burst_q  <= burst_d;
      beat_q   <= beat_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end
endmodule
